// File: rtl/hpi_responder_pkg.sv
// ---------------------------------------------------------------------------
// hpi_responder_pkg
//   Shared types for the HPI responder: the four HPI register ports selected
//   by OTG_ADDR, the bus FSM states, and the STATUS register bit positions.
// ---------------------------------------------------------------------------
package hpi_responder_pkg;

    // HPI register port, encoded exactly as OTG_ADDR.
    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDRESS = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_port_e;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRdDrive,
        StWrActive
    } hpi_state_e;

    localparam int unsigned MBX_IN_BIT  = 0;
    localparam int unsigned MBX_OUT_BIT = 8;

    // STATUS read value: only the two mailbox flags are populated.
    function automatic logic [15:0] status_word(logic mbx_out, logic mbx_in);
        logic [15:0] w;
        w              = '0;
        w[MBX_OUT_BIT] = mbx_out;
        w[MBX_IN_BIT]  = mbx_in;
        return w;
    endfunction

endpackage

// File: rtl/hpi_responder_if.sv
// ---------------------------------------------------------------------------
// hpi_responder_if
//   HPI strobe/address/interrupt bundle between a host (master) and the
//   responder (slave). The 16-bit data bus is bidirectional and is carried
//   as a separate inout port on the responder.
//   OTG_ADDR  : register port select (DATA/MAILBOX/ADDRESS/STATUS)
//   OTG_CS_N  : chip select, active low
//   OTG_RD_N  : read strobe, active low
//   OTG_WR_N  : write strobe, active low
//   OTG_INT   : responder interrupt, high while mailbox-out is pending
// ---------------------------------------------------------------------------
interface hpi_responder_if;

    logic [1:0] OTG_ADDR;
    logic       OTG_CS_N;
    logic       OTG_RD_N;
    logic       OTG_WR_N;
    logic       OTG_INT;

    modport master (
        output OTG_ADDR,
        output OTG_CS_N,
        output OTG_RD_N,
        output OTG_WR_N,
        input  OTG_INT
    );

    modport slave (
        input  OTG_ADDR,
        input  OTG_CS_N,
        input  OTG_RD_N,
        input  OTG_WR_N,
        output OTG_INT
    );

endinterface

// File: rtl/hpi_responder_ram.sv
// ---------------------------------------------------------------------------
// hpi_responder_ram
//   Single-port synchronous 16-bit word RAM with a one-cycle registered read
//   (read-before-write). Written so synthesis infers block RAM; no reset.
//   clk   : clock
//   we    : write enable for the addressed word
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid one cycle after addr is presented
// ---------------------------------------------------------------------------
module hpi_responder_ram #(
    parameter  int unsigned MEM_WORDS = 256,
    localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/hpi_responder.sv
// ---------------------------------------------------------------------------
// hpi_responder
//   Responder (chip) side of the HPI bus. Decodes the host strobes, serves a
//   word RAM through an auto-incrementing byte address register, and offers
//   a two-way mailbox with STATUS flags and an interrupt line.
//   Clk          : system clock; host strobes are sampled on its rising edge
//   Reset_n      : asynchronous active-low reset
//   hpi          : strobes, port select and OTG_INT (slave modport)
//   OTG_DATA     : bidirectional data; driven only while read data is valid
//   mbx_in_data  : last word the host wrote to MAILBOX
//   mbx_in_valid : STATUS.MBX_IN
//   mbx_in_ack   : local consumer pulse, clears MBX_IN
//   mbx_out_data : local word offered to the host
//   mbx_out_wr   : pulse, loads mailbox-out and sets STATUS.MBX_OUT
//   proto_err    : sticky, set when RD_N and WR_N are both low under CS_N
// ---------------------------------------------------------------------------
module hpi_responder
    import hpi_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 256,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [15:0] OOR_DATA     = 16'hDEAD
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    hpi_responder_if.slave        hpi,
    inout  wire  [15:0]           OTG_DATA,
    output logic [15:0]           mbx_in_data,
    output logic                  mbx_in_valid,
    input  logic                  mbx_in_ack,
    input  logic [15:0]           mbx_out_data,
    input  logic                  mbx_out_wr,
    output logic                  proto_err
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    // Holds READ_LATENCY-1; at least one bit so READ_LATENCY=1 still elaborates.
    localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [16:0] MEM_BYTES = 17'(2 * MEM_WORDS);

    hpi_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    hpi_port_e   port_q, port_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] out_q, out_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] mbx_in_q, mbx_in_d;
    logic [15:0] mbx_out_q, mbx_out_d;
    logic        mbx_in_flag_q, mbx_in_flag_d;
    logic        mbx_out_flag_q, mbx_out_flag_d;
    logic        oe_q, oe_d;
    logic        perr_q, perr_d;

    logic        sel, rd, wr, both;
    logic        addr_in_range;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [15:0] read_word;

    assign sel  = ~hpi.OTG_CS_N;
    assign rd   = sel & ~hpi.OTG_RD_N;
    assign wr   = sel & ~hpi.OTG_WR_N;
    assign both = rd & wr;

    assign addr_in_range = ({1'b0, addr_q} < MEM_BYTES);

    // RAM address always follows addr_reg; it cannot change during a read,
    // so the word is stable well before RD_WAIT finishes.
    hpi_responder_ram #(
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .addr  (addr_q[AW:1]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        read_word = '0;
        unique case (port_q)
            HPI_DATA:    read_word = addr_in_range ? ram_rdata : OOR_DATA;
            HPI_MAILBOX: read_word = mbx_out_q;
            HPI_ADDRESS: read_word = addr_q;
            HPI_STATUS:  read_word = status_word(mbx_out_flag_q, mbx_in_flag_q);
            default:     read_word = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        port_d         = port_q;
        addr_d         = addr_q;
        out_d          = out_q;
        wdata_d        = wdata_q;
        mbx_in_d       = mbx_in_q;
        mbx_out_d      = mbx_out_q;
        mbx_in_flag_d  = mbx_in_flag_q;
        mbx_out_flag_d = mbx_out_flag_q;
        oe_d           = oe_q;
        perr_d         = perr_q;
        ram_we         = 1'b0;

        if (both) begin
            perr_d = 1'b1;
        end

        // Local clears go first so a host-side set in the same cycle wins.
        if (mbx_in_ack) begin
            mbx_in_flag_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (both) begin
                    state_d = StIdle;
                end else if (rd) begin
                    state_d = StRdWait;
                    cnt_d   = CW'(READ_LATENCY - 1);
                    port_d  = hpi_port_e'(hpi.OTG_ADDR);
                end else if (wr) begin
                    state_d = StWrActive;
                    port_d  = hpi_port_e'(hpi.OTG_ADDR);
                    wdata_d = OTG_DATA;
                end
            end

            StRdWait: begin
                if (!rd) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StRdDrive;
                    out_d   = read_word;
                    oe_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            StRdDrive: begin
                // Read side effects are taken only once the host lets go.
                if (!rd) begin
                    state_d = StIdle;
                    oe_d    = 1'b0;
                    unique case (port_q)
                        HPI_DATA:    addr_d         = addr_q + 16'd2;
                        HPI_MAILBOX: mbx_out_flag_d = 1'b0;
                        HPI_ADDRESS: ;
                        HPI_STATUS:  ;
                        default:     ;
                    endcase
                end
            end

            StWrActive: begin
                if (wr) begin
                    wdata_d = OTG_DATA;
                end else begin
                    state_d = StIdle;
                    unique case (port_q)
                        HPI_DATA: begin
                            ram_we = addr_in_range;
                            addr_d = addr_q + 16'd2;
                        end
                        HPI_MAILBOX: begin
                            mbx_in_d      = wdata_q;
                            mbx_in_flag_d = 1'b1;
                        end
                        HPI_ADDRESS: begin
                            addr_d = {wdata_q[15:1], 1'b0};
                        end
                        HPI_STATUS: begin
                            if (wdata_q[MBX_IN_BIT]) begin
                                mbx_in_flag_d = 1'b0;
                            end
                            if (wdata_q[MBX_OUT_BIT]) begin
                                mbx_out_flag_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            default: begin
                state_d = StIdle;
                oe_d    = 1'b0;
            end
        endcase

        // Local mailbox-out load overrides any host clear in the same cycle.
        if (mbx_out_wr) begin
            mbx_out_d      = mbx_out_data;
            mbx_out_flag_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            port_q         <= HPI_DATA;
            addr_q         <= '0;
            out_q          <= '0;
            wdata_q        <= '0;
            mbx_in_q       <= '0;
            mbx_out_q      <= '0;
            mbx_in_flag_q  <= 1'b0;
            mbx_out_flag_q <= 1'b0;
            oe_q           <= 1'b0;
            perr_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            port_q         <= port_d;
            addr_q         <= addr_d;
            out_q          <= out_d;
            wdata_q        <= wdata_d;
            mbx_in_q       <= mbx_in_d;
            mbx_out_q      <= mbx_out_d;
            mbx_in_flag_q  <= mbx_in_flag_d;
            mbx_out_flag_q <= mbx_out_flag_d;
            oe_q           <= oe_d;
            perr_q         <= perr_d;
        end
    end

    assign OTG_DATA     = oe_q ? out_q : 'z;
    assign hpi.OTG_INT  = mbx_out_flag_q;
    assign mbx_in_data  = mbx_in_q;
    assign mbx_in_valid = mbx_in_flag_q;
    assign proto_err    = perr_q;

endmodule

// File: tb/tb_hpi_responder.sv
// ---------------------------------------------------------------------------
// tb_hpi_responder
//   Self-checking bench for hpi_responder. Host reads push their expected
//   word into a scoreboard queue; the word is popped and compared on the
//   cycle the responder is due to drive the bus. A pull-up on the data bus
//   makes an undriven bus read as 16'hFFFF.
// ---------------------------------------------------------------------------
module tb_hpi_responder;
    import hpi_responder_pkg::*;

    localparam int unsigned MEM_WORDS    = 4096;
    localparam int unsigned READ_LATENCY = 2;
    localparam logic [15:0] PULL         = 16'hFFFF;

    logic        Clk;
    logic        Reset_n;
    logic        host_oe;
    logic [15:0] host_wdata;
    logic [15:0] mbx_in_data;
    logic        mbx_in_valid;
    logic        mbx_in_ack;
    logic [15:0] mbx_out_data;
    logic        mbx_out_wr;
    logic        proto_err;
    wire  [15:0] data_bus;

    hpi_responder_if hpi ();

    pullup (data_bus);
    assign data_bus = host_oe ? host_wdata : 'z;

    hpi_responder #(
        .MEM_WORDS    (MEM_WORDS),
        .READ_LATENCY (READ_LATENCY),
        .OOR_DATA     (16'hDEAD)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .hpi          (hpi),
        .OTG_DATA     (data_bus),
        .mbx_in_data  (mbx_in_data),
        .mbx_in_valid (mbx_in_valid),
        .mbx_in_ack   (mbx_in_ack),
        .mbx_out_data (mbx_out_data),
        .mbx_out_wr   (mbx_out_wr),
        .proto_err    (proto_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_q [$];
    string       tag_q [$];

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at the falling edge after the responder should start driving.
    task automatic rd_begin(input hpi_port_e port, input string tag);
        @(negedge Clk);
        hpi.OTG_ADDR = port;
        hpi.OTG_CS_N = 1'b0;
        hpi.OTG_RD_N = 1'b0;
        @(posedge Clk);
        repeat (READ_LATENCY - 1) @(posedge Clk);
        @(negedge Clk);
        check_eq({tag, "_early"}, data_bus, PULL);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic rd_end(input string tag);
        hpi.OTG_CS_N = 1'b1;
        hpi.OTG_RD_N = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_eq({tag, "_z"}, data_bus, PULL);
    endtask

    task automatic host_read(input hpi_port_e port, input logic [15:0] exp, input string tag);
        logic [15:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        rd_begin(port, tag);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, data_bus, e);
        rd_end(tag);
    endtask

    task automatic host_write(input hpi_port_e port, input logic [15:0] data);
        @(negedge Clk);
        hpi.OTG_ADDR = port;
        host_wdata   = data;
        host_oe      = 1'b1;
        hpi.OTG_CS_N = 1'b0;
        hpi.OTG_WR_N = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        hpi.OTG_CS_N = 1'b1;
        hpi.OTG_WR_N = 1'b1;
        host_oe      = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic mbx_out_load(input logic [15:0] data);
        @(negedge Clk);
        mbx_out_data = data;
        mbx_out_wr   = 1'b1;
        @(negedge Clk);
        mbx_out_wr   = 1'b0;
    endtask

    initial begin
        Reset_n      = 1'b0;
        host_oe      = 1'b0;
        host_wdata   = '0;
        mbx_in_ack   = 1'b0;
        mbx_out_data = '0;
        mbx_out_wr   = 1'b0;
        hpi.OTG_ADDR = 2'd0;
        hpi.OTG_CS_N = 1'b1;
        hpi.OTG_RD_N = 1'b1;
        hpi.OTG_WR_N = 1'b1;

        repeat (3) @(negedge Clk);
        check_eq("rst_bus", data_bus, PULL);
        check_eq("rst_int", 16'(hpi.OTG_INT), 16'h0);
        check_eq("rst_mbx_valid", 16'(mbx_in_valid), 16'h0);
        check_eq("rst_perr", 16'(proto_err), 16'h0);
        Reset_n = 1'b1;

        host_read(HPI_STATUS, 16'h0000, "rst_status");
        host_read(HPI_ADDRESS, 16'h0000, "rst_addr");

        // Burst write then burst read through the auto-incrementing address.
        host_write(HPI_ADDRESS, 16'h1000);
        host_write(HPI_DATA, 16'hAAAA);
        host_write(HPI_DATA, 16'h5555);
        host_read(HPI_ADDRESS, 16'h1004, "burst_addr_after_wr");
        host_write(HPI_ADDRESS, 16'h1001);
        host_read(HPI_ADDRESS, 16'h1000, "addr_bit0_forced");
        host_read(HPI_DATA, 16'hAAAA, "burst_rd0");
        host_read(HPI_DATA, 16'h5555, "burst_rd1");
        host_read(HPI_ADDRESS, 16'h1004, "burst_addr_after_rd");

        // Mailbox in.
        host_write(HPI_MAILBOX, 16'h0042);
        check_eq("mbx_in_valid", 16'(mbx_in_valid), 16'h1);
        check_eq("mbx_in_data", mbx_in_data, 16'h0042);
        host_read(HPI_STATUS, 16'h0001, "mbx_in_status");
        @(negedge Clk);
        mbx_in_ack = 1'b1;
        @(negedge Clk);
        mbx_in_ack = 1'b0;
        check_eq("mbx_in_acked", 16'(mbx_in_valid), 16'h0);
        host_read(HPI_STATUS, 16'h0000, "mbx_in_status_clr");

        // Mailbox out.
        mbx_out_load(16'hBEEF);
        check_eq("mbx_out_int", 16'(hpi.OTG_INT), 16'h1);
        host_read(HPI_STATUS, 16'h0100, "mbx_out_status");
        host_read(HPI_MAILBOX, 16'hBEEF, "mbx_out_rd");
        check_eq("mbx_out_int_clr", 16'(hpi.OTG_INT), 16'h0);

        // Local load coinciding with the host mailbox read release: set wins.
        mbx_out_load(16'h0BAD);
        rd_begin(HPI_MAILBOX, "setwin");
        check_eq("setwin_rd", data_bus, 16'h0BAD);
        mbx_out_data = 16'h0123;
        mbx_out_wr   = 1'b1;
        rd_end("setwin");
        mbx_out_wr   = 1'b0;
        check_eq("setwin_int", 16'(hpi.OTG_INT), 16'h1);
        host_read(HPI_MAILBOX, 16'h0123, "setwin_data");

        // STATUS write-1-to-clear of MBX_OUT.
        mbx_out_load(16'h7777);
        host_write(HPI_STATUS, 16'h0100);
        check_eq("w1c_int", 16'(hpi.OTG_INT), 16'h0);

        // Boundaries: out-of-range read and address wrap.
        host_write(HPI_ADDRESS, 16'hFFFE);
        host_read(HPI_DATA, 16'hDEAD, "oor_rd");
        host_read(HPI_ADDRESS, 16'h0000, "addr_wrap");

        // Read aborted in RD_WAIT leaves addr_reg alone.
        host_write(HPI_ADDRESS, 16'h0010);
        @(negedge Clk);
        hpi.OTG_ADDR = HPI_DATA;
        hpi.OTG_CS_N = 1'b0;
        hpi.OTG_RD_N = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        hpi.OTG_CS_N = 1'b1;
        hpi.OTG_RD_N = 1'b1;
        repeat (READ_LATENCY + 1) @(negedge Clk);
        check_eq("abort_bus", data_bus, PULL);
        host_read(HPI_ADDRESS, 16'h0010, "abort_addr");

        // Protocol error: both strobes low.
        host_write(HPI_ADDRESS, 16'h1000);
        @(negedge Clk);
        hpi.OTG_ADDR = HPI_DATA;
        hpi.OTG_CS_N = 1'b0;
        hpi.OTG_RD_N = 1'b0;
        hpi.OTG_WR_N = 1'b0;
        repeat (READ_LATENCY + 2) @(negedge Clk);
        check_eq("perr_bus", data_bus, PULL);
        check_eq("perr_set", 16'(proto_err), 16'h1);
        hpi.OTG_CS_N = 1'b1;
        hpi.OTG_RD_N = 1'b1;
        hpi.OTG_WR_N = 1'b1;
        repeat (2) @(negedge Clk);
        check_eq("perr_sticky", 16'(proto_err), 16'h1);
        host_read(HPI_ADDRESS, 16'h1000, "perr_addr");
        host_read(HPI_DATA, 16'hAAAA, "perr_ram");
        host_read(HPI_STATUS, 16'h0000, "perr_status");

        // Reset in the middle of RD_DRIVE.
        mbx_out_load(16'h0777);
        rd_begin(HPI_MAILBOX, "rstmid");
        check_eq("rstmid_drive", data_bus, 16'h0777);
        Reset_n = 1'b0;
        #1;
        check_eq("rstmid_bus", data_bus, PULL);
        check_eq("rstmid_int", 16'(hpi.OTG_INT), 16'h0);
        check_eq("rstmid_perr", 16'(proto_err), 16'h0);
        @(negedge Clk);
        hpi.OTG_CS_N = 1'b1;
        hpi.OTG_RD_N = 1'b1;
        @(negedge Clk);
        Reset_n = 1'b1;
        host_read(HPI_STATUS, 16'h0000, "rstmid_status");
        host_read(HPI_MAILBOX, 16'h0000, "rstmid_mbx");

        check_eq("sb_empty", 16'(exp_q.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hpi_responder.md
Name: hpi_responder

Overview:
Behavioural-synthesizable model of the CY7C67200 side of the HPI bus; the responder end of hpi_io_intf. It decodes OTG_ADDR/CS_N/RD_N/WR_N strobes, serves a word RAM through an auto-incrementing address register, and provides a mailbox with status and interrupt. It replaces the EZ-OTG chip in simulation and FPGA loopback builds, so USB keyboard firmware paths can be exercised without silicon.

Parameters:
MEM_WORDS, 256, depth of internal 16-bit RAM (power of two); byte address bits [log2(MEM_WORDS):1] index it
READ_LATENCY, 2, Clk cycles from read strobe sampled to OTG_DATA driven (>=1)
OOR_DATA, 16'hDEAD, read value for addresses >= 2*MEM_WORDS

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  asynchronous, active-low reset
OTG_DATA  inout  16  HPI data; driven only when read data valid, else 'z
OTG_ADDR  in  2  0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS
OTG_CS_N  in  1  chip select, active low
OTG_RD_N  in  1  read strobe, active low
OTG_WR_N  in  1  write strobe, active low
OTG_INT  out  1  high while STATUS.MBX_OUT=1
mbx_in_data  out  16  last host-written mailbox word
mbx_in_valid  out  1  = STATUS.MBX_IN
mbx_in_ack  in  1  local consumer pulse; clears MBX_IN
mbx_out_data  in  16  local word for host
mbx_out_wr  in  1  pulse; loads mailbox-out, sets MBX_OUT
proto_err  out  1  sticky; RD_N and WR_N both low with CS_N low

Behaviour:
- Reset (async, Reset_n=0): FSM=IDLE, addr_reg=0, mailbox regs=0, STATUS=0, OTG_DATA='z, OTG_INT=0, mbx_in_valid=0, proto_err=0. RAM contents not reset.
- Strobes are same-domain, sampled on posedge Clk; no synchronizers. Access = CS_N=0 & (RD_N=0 xor WR_N=0).
- FSM states: IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE.
- IDLE: read sampled -> RD_WAIT, cnt=READ_LATENCY-1, latch OTG_ADDR. Write sampled -> WR_ACTIVE, latch OTG_ADDR. Both strobes low -> proto_err<=1, stay IDLE.
- RD_WAIT: cnt decrements; at cnt=0 -> RD_DRIVE, load out_reg from selected source, oe<=1. Strobe released in RD_WAIT -> abort to IDLE with no side effects.
- RD_DRIVE: OTG_DATA=out_reg while oe. Strobe released -> IDLE, oe<=0 (OTG_DATA 'z one cycle after release is sampled). Side effects happen at release: DATA port addr_reg+=2; MAILBOX port clears MBX_OUT.
- WR_ACTIVE: OTG_DATA captured every cycle while WR_N=0. WR_N/CS_N release -> commit last captured word -> IDLE. DATA: RAM write if in range, else drop; addr_reg+=2 either way. MAILBOX: mbx_in_data<=word, MBX_IN<=1. ADDRESS: addr_reg<=word with bit0 forced 0. STATUS: write-1-to-clear on bits 0 and 8.
- Read sources: DATA=RAM[addr_reg>>1] or OOR_DATA; MAILBOX=mailbox-out reg; ADDRESS=addr_reg; STATUS={7'b0,MBX_OUT,7'b0,MBX_IN}.
- addr_reg is 16-bit; wraps 16'hFFFE -> 16'h0000.
- Same-cycle events: mbx_out_wr coinciding with a host MAILBOX read release leaves MBX_OUT=1 and loads new data (set wins). mbx_in_ack coinciding with a host mailbox write commit leaves MBX_IN=1 (set wins).
- Deassertion of CS_N alone counts as strobe release.
- Reset mid-access: immediate return to IDLE, OTG_DATA 'z, no commit.

Decomposition:
- hpi_pkg: typedef enum hpi_port_e {HPI_DATA, HPI_MAILBOX, HPI_ADDRESS, HPI_STATUS}; FSM state enum; STATUS bit indices MBX_IN_BIT=0, MBX_OUT_BIT=8.
- Sub-module hpi_ram: single-port sync 16-bit RAM (MEM_WORDS), 1-cycle read, inferred block RAM; READ_LATENCY>=1 covers its latency.

Test Plan:
- Reset: Reset_n=0 mid-RD_DRIVE -> OTG_DATA='z, OTG_INT=0, STATUS read after release returns 16'h0000.
- Burst write/read: ADDRESS<=16'h1000, DATA writes 16'hAAAA, 16'h5555 (MEM_WORDS=4096) -> ADDRESS reads 16'h1004; ADDRESS<=16'h1000, two DATA reads return AAAA, 5555; data valid exactly READ_LATENCY cycles after strobe.
- Mailbox in: host writes MAILBOX 16'h0042 -> mbx_in_valid=1, mbx_in_data=16'h0042, STATUS=16'h0001; mbx_in_ack -> STATUS=16'h0000.
- Mailbox out: mbx_out_wr with 16'hBEEF -> OTG_INT=1, STATUS=16'h0100; host reads MAILBOX=16'hBEEF, OTG_INT=0 one cycle after release.
- Boundaries: ADDRESS<=16'hFFFE, DATA read -> 16'hDEAD, ADDRESS reads 16'h0000; read aborted in RD_WAIT -> addr_reg unchanged.
- Protocol error: CS_N=0, RD_N=0, WR_N=0 -> proto_err=1 sticky, no RAM/register change, OTG_DATA stays 'z.
